usb_midi_parser: RTL and testbench
==================================

Name: usb_midi_parser

Overview:
- Consumes the received-byte stream from usb_controller, the MAX3421E host controller, in the 25 MHz USB clock domain.
- Frames the stream into 4-byte USB-MIDI event packets and decodes Note On and Note Off messages.
- Emits note events through a small valid/ready FIFO toward the synth voice logic.
- Maintains a held-note bitmap, which drives gate_out and last_note_out for a monophonic path.

Parameters:
- CHANNEL_FILTER, default 16: MIDI channel to accept, 0-15. The value 16 accepts all channels (omni).
- FIFO_DEPTH, default 4: number of event FIFO entries. Must be a power of two, at least 2.

Ports:
- clk_in  input  1  system clock, the 25 MHz USB domain clock.
- rst_in  input  1  reset, synchronous, active-low.
- byte_in  input  8  received byte from usb_controller.
- byte_valid_in  input  1  byte_in is valid this cycle; one-cycle strobe per byte.
- packet_start_in  input  1  qualifies byte_in as byte 0 of a USB-MIDI packet; only meaningful when byte_valid_in=1.
- event_valid_out  output  1  FIFO head holds a valid event.
- event_ready_in  input  1  consumer accepts the head event.
- event_on_out  output  1  1 = note on, 0 = note off.
- event_note_out  output  7  MIDI note number.
- event_velocity_out  output  7  velocity; forced to 0 for note-off events.
- event_channel_out  output  4  MIDI channel.
- gate_out  output  1  at least one note is held.
- last_note_out  output  7  note number of the most recent accepted note-on.
- err_count_out  output  8  saturating count of malformed packets and FIFO drops.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - byte index cleared to 0; FIFO emptied; bitmap cleared.
  - All outputs become 0: event_valid_out, event fields, gate_out, last_note_out, err_count_out.
  - Reset arriving mid-packet discards the partial packet and does not count an error.
- Framing:
  - A 2-bit byte index advances only on byte_valid_in.
  - If packet_start_in=1, the byte is treated as byte 0 regardless of the index.
  - If the index was nonzero at that point, the partial packet is discarded and err_count increments.
  - A byte without packet_start_in while the index is 0 is ignored; no error is counted.
  - After byte 3 the index wraps to 0.
- Byte 0: CIN = byte_in[3:0]. CIN 0x9 is note on, 0x8 is note off. Any other CIN: the packet is consumed silently, with no event and no error.
- Byte 1: status byte. Require bit7=1 and status[7:4]==CIN, otherwise the packet is malformed. The channel is status[3:0].
- Bytes 2 and 3: note and velocity. Each requires bit7=0, otherwise the packet is malformed.
- Malformed packet handling:
  - The malformed flag is sticky for the rest of the packet.
  - At byte 3: no event is produced and err_count increments once.
- Note on with velocity 0 is treated as note off.
- Channel filter: if CHANNEL_FILTER<16 and the channel does not match, the packet is consumed silently.
- Accept at byte 3 (valid, filtered-in packet), in that cycle:
  - Bitmap bit[note] is set (on) or cleared (off).
  - On note-on, last_note is updated.
  - The event is pushed to the FIFO.
- Bitmap update is independent of the FIFO. A note-off dropped because the FIFO is full still clears its bit.
- Outputs:
  - gate_out = OR of all bitmap bits.
  - gate_out and last_note_out are registered: they update the cycle after the byte-3 edge.
- FIFO:
  - Latency: event_valid_out rises on the cycle after the byte-3 edge when the FIFO was empty.
  - Pop occurs on event_valid_out & event_ready_in.
  - Head fields stay stable while valid=1 and ready=0.
  - Full FIFO with push and no pop in the same cycle: the event is dropped and err_count increments.
  - Full FIFO with push and pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Empty FIFO with push: no bypass; the event appears next cycle.
- err_count saturates at 255, never wraps. Two error sources in the same cycle count as +1.

Decomposition:
- Package usb_midi_pkg holds:
  - CIN_NOTE_ON and CIN_NOTE_OFF constants.
  - STATUS_NOTE_ON and STATUS_NOTE_OFF nibble constants.
  - CHANNEL_OMNI=16.
  - Packed typedef midi_event_t {on, note[6:0], velocity[6:0], channel[3:0]}.
- One sub-module: midi_event_fifo. It is a synchronous FIFO of midi_event_t with push/full/pop/empty and the simultaneous push-pop-when-full rule above.
- Framing, decode and bitmap logic live in usb_midi_parser.

Test Plan:
- Packet 09 90 3C 64 with ready=1 -> one cycle after byte 3:
  - valid=1, on=1, note=0x3C, vel=0x64, ch=0.
  - gate_out=1, last_note_out=0x3C.
- Then packet 08 80 3C 40 -> event on=0, vel=0, note=0x3C; gate_out falls to 0.
- Packet 09 95 40 00 with CHANNEL_FILTER=16 -> note-off event with ch=5.
- Same packet 09 95 40 00 with CHANNEL_FILTER=2 -> no event and err_count unchanged.
- Packet start after two bytes (09 90, then start of 09 90 3E 7F) -> err_count=1; only the note-0x3E event is produced.
- Packets 09 90 3C 64 and 09 91 48 64 (second packet: data byte 0x48 replaced by 0xC8) -> first packet gives one event; second gives no event and err_count=1. CIN 0xB packet -> no event, no error.
- ready=0 with 6 note-on packets, FIFO_DEPTH=4:
  - 4 events queued; err_count=2; gate/bitmap reflects all 6 notes.
  - Head fields stay constant.
  - Raising ready drains the 4 events in order.
- Reset asserted after byte 2 of a packet -> all outputs 0 next cycle, err_count=0, next full packet decodes normally.

Source files
------------

// File: rtl/usb_midi_pkg.sv
// Shared constants and the note-event record used by the USB-MIDI parser and its FIFO.
package usb_midi_pkg;

  localparam logic [3:0] CIN_NOTE_ON     = 4'h9;
  localparam logic [3:0] CIN_NOTE_OFF    = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
  localparam int         CHANNEL_OMNI    = 16;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [3:0] channel;
  } midi_event_t;

endpackage

// File: rtl/midi_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
import usb_midi_pkg::*;

module midi_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  midi_event_t push_data,
  output logic        full,
  input  logic        pop,
  output midi_event_t head,
  output logic        empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  midi_event_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/usb_midi_parser.sv
// Frames USB-MIDI 4-byte packets, decodes note on/off into an event FIFO and
// tracks held notes for a monophonic gate / last-note path.
import usb_midi_pkg::*;

module usb_midi_parser #(
  parameter int CHANNEL_FILTER = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  input  logic       packet_start_in,
  output logic       event_valid_out,
  input  logic       event_ready_in,
  output logic       event_on_out,
  output logic [6:0] event_note_out,
  output logic [6:0] event_velocity_out,
  output logic [3:0] event_channel_out,
  output logic       gate_out,
  output logic [6:0] last_note_out,
  output logic [7:0] err_count_out
);
  logic [1:0]   idx;
  logic [3:0]   cin;
  logic         is_note;
  logic         malformed;
  logic [3:0]   channel;
  logic [6:0]   note;
  logic [127:0] bitmap;
  logic [127:0] bitmap_next;

  logic        restart_err, at_byte3, bad_final, malformed_err;
  logic        chan_ok, accept, ev_on, fifo_drop, pop_fire;
  logic        fifo_full, fifo_empty;
  logic [3:0]  status_expect;
  midi_event_t push_data, head;

  assign status_expect = (cin == CIN_NOTE_ON) ? STATUS_NOTE_ON : STATUS_NOTE_OFF;
  assign restart_err   = byte_valid_in && packet_start_in && (idx != 2'd0);
  assign at_byte3      = byte_valid_in && !packet_start_in && (idx == 2'd3);
  assign bad_final     = malformed || byte_in[7];
  assign malformed_err = at_byte3 && is_note && bad_final;
  assign chan_ok       = (CHANNEL_FILTER >= CHANNEL_OMNI) || (channel == 4'(CHANNEL_FILTER));
  assign accept        = at_byte3 && is_note && !bad_final && chan_ok;
  // A note-on with velocity 0 is a note-off by MIDI convention.
  assign ev_on         = (cin == CIN_NOTE_ON) && (byte_in[6:0] != 7'd0);
  assign pop_fire      = event_ready_in && !fifo_empty;
  assign fifo_drop     = accept && fifo_full && !pop_fire;

  always_comb begin
    push_data.on       = ev_on;
    push_data.note     = note;
    push_data.velocity = ev_on ? byte_in[6:0] : 7'd0;
    push_data.channel  = channel;
  end

  always_comb begin
    bitmap_next = bitmap;
    if (accept) bitmap_next[note] = ev_on;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      idx           <= 2'd0;
      cin           <= 4'd0;
      is_note       <= 1'b0;
      malformed     <= 1'b0;
      channel       <= 4'd0;
      note          <= 7'd0;
      bitmap        <= '0;
      gate_out      <= 1'b0;
      last_note_out <= 7'd0;
      err_count_out <= 8'd0;
    end else begin
      if (byte_valid_in) begin
        if (packet_start_in) begin
          idx       <= 2'd1;
          cin       <= byte_in[3:0];
          is_note   <= (byte_in[3:0] == CIN_NOTE_ON) || (byte_in[3:0] == CIN_NOTE_OFF);
          malformed <= 1'b0;
        end else if (idx != 2'd0) begin
          idx <= idx + 2'd1;
          case (idx)
            2'd1: begin
              channel   <= byte_in[3:0];
              malformed <= malformed || !byte_in[7] || (byte_in[7:4] != status_expect);
            end
            2'd2: begin
              note      <= byte_in[6:0];
              malformed <= malformed || byte_in[7];
            end
            default: malformed <= malformed;
          endcase
        end
      end
      bitmap   <= bitmap_next;
      gate_out <= |bitmap_next;
      if (accept && ev_on) last_note_out <= note;
      // Coincident error sources count once; saturate at 255.
      if ((restart_err || malformed_err || fifo_drop) && (err_count_out != 8'hFF))
        err_count_out <= err_count_out + 8'd1;
    end
  end

  midi_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (accept),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (event_ready_in),
    .head      (head),
    .empty     (fifo_empty)
  );

  assign event_valid_out    = !fifo_empty;
  assign event_on_out       = fifo_empty ? 1'b0 : head.on;
  assign event_note_out     = fifo_empty ? 7'd0 : head.note;
  assign event_velocity_out = fifo_empty ? 7'd0 : head.velocity;
  assign event_channel_out  = fifo_empty ? 4'd0 : head.channel;

endmodule

// File: tb/tb_usb_midi_parser.sv
// Directed bench: an omni parser and a channel-2 filtered parser share one byte stream.
module tb_usb_midi_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_d = 8'd0;
  logic       byte_valid = 1'b0;
  logic       pkt_start = 1'b0;
  logic       ready = 1'b0;

  logic       o_valid, o_on, o_gate;
  logic [6:0] o_note, o_vel, o_last;
  logic [3:0] o_ch;
  logic [7:0] o_err;

  logic       f_valid, f_on, f_gate;
  logic [6:0] f_note, f_vel, f_last;
  logic [3:0] f_ch;
  logic [7:0] f_err;

  int vectors = 0;
  int miscompares = 0;

  always #20 clk = ~clk;

  usb_midi_parser #(.CHANNEL_FILTER(16), .FIFO_DEPTH(4)) u_omni (
    .clk_in(clk), .rst_in(rst_n), .byte_in(byte_d), .byte_valid_in(byte_valid),
    .packet_start_in(pkt_start), .event_valid_out(o_valid), .event_ready_in(ready),
    .event_on_out(o_on), .event_note_out(o_note), .event_velocity_out(o_vel),
    .event_channel_out(o_ch), .gate_out(o_gate), .last_note_out(o_last),
    .err_count_out(o_err)
  );

  usb_midi_parser #(.CHANNEL_FILTER(2), .FIFO_DEPTH(4)) u_f2 (
    .clk_in(clk), .rst_in(rst_n), .byte_in(byte_d), .byte_valid_in(byte_valid),
    .packet_start_in(pkt_start), .event_valid_out(f_valid), .event_ready_in(ready),
    .event_on_out(f_on), .event_note_out(f_note), .event_velocity_out(f_vel),
    .event_channel_out(f_ch), .gate_out(f_gate), .last_note_out(f_last),
    .err_count_out(f_err)
  );

  task automatic send_byte(input logic [7:0] b, input logic s);
    @(negedge clk);
    byte_d = b; byte_valid = 1'b1; pkt_start = s;
    @(posedge clk);
    #1;
    byte_valid = 1'b0; pkt_start = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; byte_valid = 1'b0; pkt_start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    vectors++; if ({o_on, o_note, o_vel, o_ch} !== 19'd0) begin miscompares++; $display("FAIL reset_fields: got %h want 0", {o_on, o_note, o_vel, o_ch}); end
    vectors++; if (o_gate !== 1'b0) begin miscompares++; $display("FAIL reset_gate: got %b want 0", o_gate); end
    vectors++; if (o_last !== 7'd0) begin miscompares++; $display("FAIL reset_last: got %h want 0", o_last); end
    vectors++; if (o_err !== 8'd0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", o_err); end
  endtask

  task automatic test_note_on_off();
    do_reset();
    ready = 1'b1;
    send_packet(8'h09, 8'h90, 8'h3C, 8'h64);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL on_valid: got %b want 1", o_valid); end
    vectors++; if ({o_on, o_note, o_vel, o_ch} !== {1'b1, 7'h3C, 7'h64, 4'h0}) begin miscompares++; $display("FAIL on_fields: got %h want %h", {o_on, o_note, o_vel, o_ch}, {1'b1, 7'h3C, 7'h64, 4'h0}); end
    vectors++; if (o_gate !== 1'b1) begin miscompares++; $display("FAIL on_gate: got %b want 1", o_gate); end
    vectors++; if (o_last !== 7'h3C) begin miscompares++; $display("FAIL on_last: got %h want 3c", o_last); end
    send_packet(8'h08, 8'h80, 8'h3C, 8'h40);
    vectors++; if ({o_valid, o_on, o_note, o_vel} !== {1'b1, 1'b0, 7'h3C, 7'h00}) begin miscompares++; $display("FAIL off_fields: got %h want %h", {o_valid, o_on, o_note, o_vel}, {1'b1, 1'b0, 7'h3C, 7'h00}); end
    vectors++; if (o_gate !== 1'b0) begin miscompares++; $display("FAIL off_gate: got %b want 0", o_gate); end
    vectors++; if (o_last !== 7'h3C) begin miscompares++; $display("FAIL off_last: got %h want 3c", o_last); end
    vectors++; if (o_err !== 8'd0) begin miscompares++; $display("FAIL off_err: got %0d want 0", o_err); end
  endtask

  task automatic test_channel_filter();
    do_reset();
    ready = 1'b1;
    send_packet(8'h09, 8'h95, 8'h40, 8'h00);
    vectors++; if ({o_valid, o_on, o_note, o_vel, o_ch} !== {1'b1, 1'b0, 7'h40, 7'h00, 4'h5}) begin miscompares++; $display("FAIL omni_vel0: got %h want %h", {o_valid, o_on, o_note, o_vel, o_ch}, {1'b1, 1'b0, 7'h40, 7'h00, 4'h5}); end
    vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL filt_drop_valid: got %b want 0", f_valid); end
    vectors++; if (f_err !== 8'd0) begin miscompares++; $display("FAIL filt_drop_err: got %0d want 0", f_err); end
    send_packet(8'h09, 8'h92, 8'h41, 8'h20);
    vectors++; if ({f_valid, f_on, f_note, f_vel, f_ch} !== {1'b1, 1'b1, 7'h41, 7'h20, 4'h2}) begin miscompares++; $display("FAIL filt_pass: got %h want %h", {f_valid, f_on, f_note, f_vel, f_ch}, {1'b1, 1'b1, 7'h41, 7'h20, 4'h2}); end
    vectors++; if (f_gate !== 1'b1) begin miscompares++; $display("FAIL filt_gate: got %b want 1", f_gate); end
  endtask

  task automatic test_restart();
    do_reset();
    ready = 1'b1;
    send_byte(8'h09, 1'b1);
    send_byte(8'h90, 1'b0);
    send_packet(8'h09, 8'h90, 8'h3E, 8'h7F);
    vectors++; if (o_err !== 8'd1) begin miscompares++; $display("FAIL restart_err: got %0d want 1", o_err); end
    vectors++; if ({o_valid, o_on, o_note, o_vel} !== {1'b1, 1'b1, 7'h3E, 7'h7F}) begin miscompares++; $display("FAIL restart_event: got %h want %h", {o_valid, o_on, o_note, o_vel}, {1'b1, 1'b1, 7'h3E, 7'h7F}); end
    @(posedge clk); #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL restart_single: got %b want 0", o_valid); end
  endtask

  task automatic test_malformed();
    do_reset();
    ready = 1'b1;
    send_packet(8'h09, 8'h90, 8'h3C, 8'h64);
    vectors++; if ({o_valid, o_note} !== {1'b1, 7'h3C}) begin miscompares++; $display("FAIL mal_first: got %h want %h", {o_valid, o_note}, {1'b1, 7'h3C}); end
    send_packet(8'h09, 8'h91, 8'hC8, 8'h64);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mal_data_valid: got %b want 0", o_valid); end
    vectors++; if (o_err !== 8'd1) begin miscompares++; $display("FAIL mal_data_err: got %0d want 1", o_err); end
    send_packet(8'h0B, 8'hB0, 8'h07, 8'h64);
    vectors++; if ({o_valid, o_err} !== {1'b0, 8'd1}) begin miscompares++; $display("FAIL cin_other: got %h want %h", {o_valid, o_err}, {1'b0, 8'd1}); end
    send_packet(8'h09, 8'h80, 8'h3C, 8'h64);
    vectors++; if ({o_valid, o_err} !== {1'b0, 8'd2}) begin miscompares++; $display("FAIL mal_status: got %h want %h", {o_valid, o_err}, {1'b0, 8'd2}); end
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b0);
    vectors++; if ({o_valid, o_err} !== {1'b0, 8'd2}) begin miscompares++; $display("FAIL stray_bytes: got %h want %h", {o_valid, o_err}, {1'b0, 8'd2}); end
    vectors++; if (o_gate !== 1'b1) begin miscompares++; $display("FAIL mal_gate: got %b want 1", o_gate); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) send_packet(8'h09, 8'h90, 8'h30 + 8'(i), 8'h10 + 8'(i));
    vectors++; if (o_err !== 8'd2) begin miscompares++; $display("FAIL full_err: got %0d want 2", o_err); end
    vectors++; if ({o_gate, o_last} !== {1'b1, 7'h35}) begin miscompares++; $display("FAIL full_gate_last: got %h want %h", {o_gate, o_last}, {1'b1, 7'h35}); end
    vectors++; if ({o_valid, o_note, o_vel} !== {1'b1, 7'h30, 7'h10}) begin miscompares++; $display("FAIL full_head: got %h want %h", {o_valid, o_note, o_vel}, {1'b1, 7'h30, 7'h10}); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if ({o_valid, o_note, o_vel} !== {1'b1, 7'h30, 7'h10}) begin miscompares++; $display("FAIL full_head_hold: got %h want %h", {o_valid, o_note, o_vel}, {1'b1, 7'h30, 7'h10}); end
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({o_valid, o_note, o_vel} !== {1'b1, 7'h30 + 7'(i), 7'h10 + 7'(i)}) begin miscompares++; $display("FAIL drain_%0d: got %h want %h", i, {o_valid, o_note, o_vel}, {1'b1, 7'h30 + 7'(i), 7'h10 + 7'(i)}); end
      @(posedge clk); #1;
    end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b want 0", o_valid); end
    for (int i = 0; i < 5; i++) send_packet(8'h08, 8'h80, 8'h30 + 8'(i), 8'h00);
    vectors++; if (o_gate !== 1'b1) begin miscompares++; $display("FAIL bitmap_held: got %b want 1", o_gate); end
    send_packet(8'h08, 8'h80, 8'h35, 8'h00);
    vectors++; if (o_gate !== 1'b0) begin miscompares++; $display("FAIL bitmap_clear: got %b want 0", o_gate); end
  endtask

  task automatic test_saturation();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 300; i++) send_byte(8'h09, 1'b1);
    vectors++; if (o_err !== 8'd255) begin miscompares++; $display("FAIL err_saturate: got %0d want 255", o_err); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    ready = 1'b1;
    send_byte(8'h09, 1'b1);
    send_packet(8'h09, 8'h90, 8'h3C, 8'h64);
    @(posedge clk); #1;
    send_byte(8'h09, 1'b1);
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b0);
    vectors++; if ({o_err, o_gate} !== {8'd1, 1'b1}) begin miscompares++; $display("FAIL pre_reset: got %h want %h", {o_err, o_gate}, {8'd1, 1'b1}); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if ({o_valid, o_gate, o_last, o_err} !== 16'd0) begin miscompares++; $display("FAIL mid_reset_outputs: got %h want 0", {o_valid, o_gate, o_last, o_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h64, 1'b0);
    send_packet(8'h09, 8'h90, 8'h40, 8'h50);
    vectors++; if ({o_valid, o_on, o_note, o_vel, o_err} !== {1'b1, 1'b1, 7'h40, 7'h50, 8'd0}) begin miscompares++; $display("FAIL post_reset_packet: got %h want %h", {o_valid, o_on, o_note, o_vel, o_err}, {1'b1, 1'b1, 7'h40, 7'h50, 8'd0}); end
  endtask

  initial begin
    test_reset();
    test_note_on_off();
    test_channel_filter();
    test_restart();
    test_malformed();
    test_fifo_full();
    test_saturation();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
